// File: rtl/rat_port_io.sv
// Port-mapped I/O block for the RAT core: LED/seven-segment registers, a TX byte FIFO,
// and button rising-edge interrupt capture with write-1-to-clear status.
module rat_port_io #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  input  logic       TX_RDY,
  output logic [7:0] IN_PORT,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  output logic       INTERRUPT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [7:0]    leds_r;
  logic [7:0]    sseg_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          irq_pending_r;
  logic [3:0]    s1_r;
  logic [3:0]    s2_r;
  logic [3:0]    s3_r;

  logic          wr_leds_s;
  logic          wr_sseg_s;
  logic          wr_fifo_s;
  logic          wr_clr_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          rise_s;
  logic [CW-1:0] count_nxt_s;
  logic          overflow_nxt_s;
  logic          irq_nxt_s;
  logic [7:0]    rd_data_s;

  assign wr_leds_s = IO_STRB && (PORT_ID == 8'h40);
  assign wr_sseg_s = IO_STRB && (PORT_ID == 8'h81);
  assign wr_fifo_s = IO_STRB && (PORT_ID == 8'h90);
  assign wr_clr_s  = IO_STRB && (PORT_ID == 8'h91);

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CNT_FULL);
  assign pop_s   = !empty_s && TX_RDY;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_s  = wr_fifo_s && (!full_s || pop_s);
  assign drop_s  = wr_fifo_s && full_s && !pop_s;
  assign rise_s  = |(s2_r & ~s3_r);

  // Next count, sticky overflow and interrupt state; a set beats a same-cycle clear.
  always_comb begin
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    irq_nxt_s      = irq_pending_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (wr_clr_s && OUT_PORT[3]) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    if (rise_s) begin
      irq_nxt_s = 1'b1;
    end else if (wr_clr_s && OUT_PORT[0]) begin
      irq_nxt_s = 1'b0;
    end else begin
      irq_nxt_s = irq_pending_r;
    end
  end

  // Read mux seen by the core in the same cycle it drives PORT_ID.
  always_comb begin
    rd_data_s = 8'h00;
    case (PORT_ID)
      8'h20:   rd_data_s = SWITCHES;
      8'h24:   rd_data_s = {4'b0000, s2_r};
      8'h91:   rd_data_s = {4'b0000, overflow_r, full_s, empty_s, irq_pending_r};
      8'h92:   rd_data_s = 8'(count_r);
      default: rd_data_s = 8'h00;
    endcase
  end

  // FIFO storage needs no reset; an empty FIFO masks the head on TX_DATA.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= OUT_PORT;
    end
  end

  // Control state, output registers and the button synchronizer chain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      leds_r        <= 8'h00;
      sseg_r        <= 8'h00;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      overflow_r    <= 1'b0;
      irq_pending_r <= 1'b0;
      s1_r          <= 4'h0;
      s2_r          <= 4'h0;
      s3_r          <= 4'h0;
    end else begin
      if (wr_leds_s) begin
        leds_r <= OUT_PORT;
      end
      if (wr_sseg_s) begin
        sseg_r <= OUT_PORT;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r       <= count_nxt_s;
      overflow_r    <= overflow_nxt_s;
      irq_pending_r <= irq_nxt_s;
      s1_r          <= BUTTONS;
      s2_r          <= s1_r;
      s3_r          <= s2_r;
    end
  end

  assign IN_PORT   = rd_data_s;
  assign LEDS      = leds_r;
  assign SSEG_VAL  = sseg_r;
  assign TX_VALID  = !empty_s;
  assign TX_DATA   = empty_s ? 8'h00 : mem_r[rd_ptr_r];
  assign INTERRUPT = irq_pending_r;

endmodule

// File: doc/rat_port_io.md
# rat_port_io

Port-mapped I/O peripheral directly downstream of the RAT CPU core. It consumes the core's `PORT_ID`, `OUT_PORT` and `IO_STRB` and drives the core's `IN_PORT` and `INTERRUPT`. It holds the LED and seven-segment output registers, buffers bytes for a serial transmitter in a small FIFO, and turns push-button rising edges into a latched interrupt request.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO depth. Power of two, 2..16.
- `CLK` in 1: system clock. All state updates on the rising edge.
- `RESET` in 1: reset. Asynchronous, active-high.
- `PORT_ID` in 8: port address from the core.
- `OUT_PORT` in 8: write data from the core.
- `IO_STRB` in 1: write strobe from the core. High for one cycle per OUT instruction.
- `SWITCHES` in 8: slide switches. Static; no synchronizer.
- `BUTTONS` in 4: asynchronous push buttons.
- `TX_RDY` in 1: transmitter ready to accept a byte.
- `IN_PORT` out 8: read data to the core.
- `LEDS` out 8: LED register.
- `SSEG_VAL` out 8: seven-segment value register.
- `TX_DATA` out 8: FIFO head byte.
- `TX_VALID` out 1: FIFO non-empty.
- `INTERRUPT` out 1: level interrupt request to the core.

## Operation
- **Write decode** (acts only when `IO_STRB`=1):
  - 0x40: `LEDS` <= `OUT_PORT`.
  - 0x81: `SSEG_VAL` <= `OUT_PORT`.
  - 0x90: push `OUT_PORT` into the FIFO.
  - 0x91: write-1-to-clear. Bit0 clears `irq_pending`; bit3 clears `overflow`.
  - Any other ID: no effect.
- **Read mux** (combinational on `PORT_ID`):
  - 0x20: `SWITCHES`.
  - 0x24: {4'b0, synchronized `BUTTONS`}.
  - 0x91: {4'b0, `overflow`, `full`, `empty`, `irq_pending`}.
  - 0x92: FIFO count, zero-extended.
  - Else: 0x00.
- **FIFO**: circular buffer with read pointer, write pointer and count of width clog2(`FIFO_DEPTH`)+1.
  - `TX_VALID` = (count != 0).
  - `TX_DATA` = head entry when non-empty, 0x00 when empty.
  - Pop when `TX_VALID` & `TX_RDY`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FIFO boundary cases**:
  - Push while full and no pop: byte dropped, `overflow` set (sticky), count unchanged.
  - Push while full with a pop in the same cycle: push accepted, count unchanged, no overflow.
  - Push while empty: no pop that cycle (`TX_VALID`=0); count becomes 1.
- **Buttons**:
  - Each bit passes through a 2-flop synchronizer (`s1`, `s2`), then a previous-value flop `s3`.
  - A rise on any bit (`s2` & ~`s3`) sets `irq_pending`.
  - `INTERRUPT` = `irq_pending`.
  - If a set and a W1C clear of `irq_pending` occur in the same cycle, the set wins.
  - If a set and a W1C clear of `overflow` occur in the same cycle, the set wins.
- **Reset**: `LEDS`, `SSEG_VAL`, pointers, count, `overflow`, `irq_pending`, `s1`/`s2`/`s3` all go to 0. Consequences:
  - `TX_VALID`=0, `TX_DATA`=0x00, `INTERRUPT`=0.
  - `IN_PORT` keeps following the read mux with reset state (e.g. 0x91 reads 0x02).
  - A button held through reset release produces one rising edge and therefore an interrupt; this is required behaviour.
  - Reset asserted mid-operation discards FIFO contents immediately.

## Timing
- `IN_PORT`: zero-cycle combinational path from `PORT_ID`. The core samples it in the same cycle.
- Writes take effect at the edge where `IO_STRB`=1; the new value is visible on outputs after that edge (1-cycle latency).
- FIFO push to `TX_VALID`: push at edge k gives `TX_VALID`=1 after edge k. A byte written into an empty FIFO appears on `TX_DATA` one cycle after the strobe.
- Pop: the head advances at the edge where `TX_VALID`&`TX_RDY`. With `TX_RDY` held high, throughput is one byte per cycle.
- Button to interrupt, for a button rising before edge k:
  - `s1`=1 after k.
  - `s2`=1 after k+1.
  - `INTERRUPT`=1 after k+2.
- W1C clear: `INTERRUPT` drops after the edge where the 0x91 write occurs.
- `INTERRUPT` stays high until cleared, regardless of button release.

## Test plan
- **Reset values**: `RESET` pulse mid-run with 3 bytes queued -> all outputs 0, count=0, `TX_VALID`=0, read of 0x91 gives 0x02.
- **Output registers**: strobe 0x40/0xA5, then 0x81/0x3C, then 0x55/0xFF -> `LEDS`=0xA5, `SSEG_VAL`=0x3C, no other change.
- **FIFO order and overflow**: `TX_RDY`=0, push 0x01..0x09 with `FIFO_DEPTH`=8 -> count=8, read of 0x91 gives 0x0C (`overflow`+`full`). Then `TX_RDY`=1 -> `TX_DATA` sequence 0x01..0x08, one per cycle; `TX_VALID` falls after the 8th pop; 0x09 is never emitted.
- **Simultaneous push/pop**: full FIFO, `TX_RDY`=1 and push 0x77 in the same cycle -> count stays 8, no overflow, 0x77 emitted last.
- **Interrupt edge, hold and set-wins**:
  - `BUTTONS`=0001 rises before edge k -> `INTERRUPT`=1 after k+2.
  - Holding the button produces no re-trigger after a W1C 0x01 clear -> `INTERRUPT`=0.
  - A new rise on bit2 coinciding with a W1C clear -> `INTERRUPT` stays 1.
- **Read mux**: `SWITCHES`=0x5A, `PORT_ID`=0x20 -> `IN_PORT`=0x5A the same cycle. `PORT_ID`=0x33 -> 0x00. `PORT_ID`=0x92 with 3 queued -> 0x03.
